// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, marks sop/eop, flags bad frames and counts good/bad frames.
// Optional feature macro: RX_CRC_CHECK_EN adds the CRC-32 check of the FCS to the bad-frame decision.
module gmii_rx_framer #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sop,
   output logic        rx_eop,
   output logic        rx_err,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   localparam logic [7:0]  PRE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE = 8'hD5;
   localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

   state_t      state;
   logic [7:0]  rxd_p0;
   logic        dv_p0;
   logic        er_p0;
   logic        first_p0;
   logic        rst_q;
   logic [7:0]  hold_data_p1;
   logic        hold_vld_p1;
   logic        hold_sop_p1;
   logic        er_p1;
   logic [10:0] len_p1;
   logic        crc_bad;
   logic        frame_bad;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   // Stage p0: register the GMII inputs; first_p0 tags the first sample after reset release
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rxd_p0   <= '0;
         dv_p0    <= 1'b0;
         er_p0    <= 1'b0;
         first_p0 <= 1'b0;
         rst_q    <= 1'b1;
      end else begin
         rxd_p0   <= gmii_rxd;
         dv_p0    <= gmii_rx_dv;
         er_p0    <= gmii_rx_er;
         first_p0 <= rst_q;
         rst_q    <= 1'b0;
      end
   end

`ifdef RX_CRC_CHECK_EN
   logic [31:0] crc_p1;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Running CRC over every byte entering the hold stage, FCS included; a clean frame leaves the residue
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         crc_p1 <= '1;
      else if (state != S_DATA)
         crc_p1 <= '1;
      else if (dv_p0)
         crc_p1 <= crc32_byte(crc_p1, rxd_p0);
   end

   assign crc_bad = (crc_p1 != 32'hDEBB20E3);
`else
   assign crc_bad = 1'b0;
`endif

   assign frame_bad = er_p1 | (len_p1 < MIN_L) | (len_p1 > MAX_L) | crc_bad;

   // Stage p1/p2: FSM on p0 samples, one-byte hold so eop lands on the byte followed by rx_dv=0
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state        <= S_IDLE;
         hold_data_p1 <= '0;
         hold_vld_p1  <= 1'b0;
         hold_sop_p1  <= 1'b0;
         er_p1        <= 1'b0;
         len_p1       <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_sop       <= 1'b0;
         rx_eop       <= 1'b0;
         rx_err       <= 1'b0;
         good_cnt     <= '0;
         bad_cnt      <= '0;
      end else begin
         rx_valid <= 1'b0;
         rx_sop   <= 1'b0;
         rx_eop   <= 1'b0;
         rx_err   <= 1'b0;
         if (state != S_DATA) begin
            hold_vld_p1 <= 1'b0;
            hold_sop_p1 <= 1'b0;
            er_p1       <= 1'b0;
            len_p1      <= '0;
         end
         case (state)
            S_IDLE: begin
               if (dv_p0) begin
                  if (first_p0)
                     state <= S_DROP;
                  else if (rxd_p0 == PRE_BYTE)
                     state <= S_PREAMBLE;
                  else if (rxd_p0 == SFD_BYTE)
                     state <= S_DATA;
                  else
                     state <= S_DROP;
               end
            end
            S_PREAMBLE: begin
               if (!dv_p0)
                  state <= S_IDLE;
               else if (rxd_p0 == SFD_BYTE)
                  state <= S_DATA;
               else if (rxd_p0 != PRE_BYTE)
                  state <= S_DROP;
            end
            S_DATA: begin
               if (dv_p0) begin
                  if (hold_vld_p1) begin
                     rx_valid <= 1'b1;
                     rx_data  <= hold_data_p1;
                     rx_sop   <= hold_sop_p1;
                  end
                  hold_data_p1 <= rxd_p0;
                  hold_vld_p1  <= 1'b1;
                  hold_sop_p1  <= !hold_vld_p1;
                  er_p1        <= er_p1 | er_p0;
                  len_p1       <= sat_inc11(len_p1);
               end else begin
                  if (hold_vld_p1) begin
                     rx_valid <= 1'b1;
                     rx_data  <= hold_data_p1;
                     rx_sop   <= hold_sop_p1;
                     rx_eop   <= 1'b1;
                     rx_err   <= frame_bad;
                     if (frame_bad)
                        bad_cnt <= sat_inc16(bad_cnt);
                     else
                        good_cnt <= sat_inc16(good_cnt);
                  end
                  hold_vld_p1 <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_DROP: begin
               if (!dv_p0)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized bench for gmii_rx_framer: a burst-level reference model predicts frames, flags and counters.
`timescale 1ns/1ps
module tb_gmii_rx_framer;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [7:0]  gmii_rxd = 8'h00;
   logic        gmii_rx_dv = 1'b0;
   logic        gmii_rx_er = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sop;
   logic        rx_eop;
   logic        rx_err;
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;

   gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .gmii_rxd  (gmii_rxd),
      .gmii_rx_dv(gmii_rx_dv),
      .gmii_rx_er(gmii_rx_er),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_sop    (rx_sop),
      .rx_eop    (rx_eop),
      .rx_err    (rx_err),
      .good_cnt  (good_cnt),
      .bad_cnt   (bad_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: collects each rx_dv burst, then applies the framing rules to the whole burst
   logic [7:0] b_byte[$];
   bit         b_er[$];
   int         b_cyc[$];
   bit         in_burst = 1'b0;
   bit         b_drop   = 1'b1;
   bit         rst_prev = 1'b1;
   logic [7:0] exp_byte[$];
   int         exp_len[$];
   bit         exp_err[$];
   int         exp_sop[$];
   int         exp_eop[$];
   int         m_good = 0;
   int         m_bad  = 0;
   logic [7:0] frm[$];

   function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (q[k]) begin
         c ^= {24'h0, q[k]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

`ifdef RX_CRC_CHECK_EN
   function automatic bit fcs_ok(input logic [7:0] q[$]);
      logic [7:0]  body[$];
      logic [31:0] c;
      int          n = q.size();
      if (n < 4) return 1'b0;
      for (int k = 0; k < n - 4; k++) body.push_back(q[k]);
      c = crc_of(body);
      return c == {q[n-1], q[n-2], q[n-3], q[n-4]};
   endfunction
`endif

   function automatic void model_end_burst();
      int i = 0;
      int p;
      int n;
      bit bad;
`ifdef RX_CRC_CHECK_EN
      logic [7:0] pl[$];
`endif
      if (!b_drop) begin
         while (i < b_byte.size() && b_byte[i] == 8'h55) i++;
         if (i + 1 < b_byte.size() && b_byte[i] == 8'hD5) begin
            p   = i + 1;
            n   = b_byte.size() - p;
            bad = (n < MIN_LEN) || (n > MAX_LEN);
            for (int k = p; k < b_byte.size(); k++) begin
               exp_byte.push_back(b_byte[k]);
               bad = bad || b_er[k];
`ifdef RX_CRC_CHECK_EN
               pl.push_back(b_byte[k]);
`endif
            end
`ifdef RX_CRC_CHECK_EN
            bad = bad || !fcs_ok(pl);
`endif
            exp_len.push_back(n);
            exp_err.push_back(bad);
            exp_sop.push_back(b_cyc[p] + 3);
            exp_eop.push_back(b_cyc[b_cyc.size()-1] + 3);
            if (bad) begin
               if (m_bad < 65535) m_bad++;
            end else begin
               if (m_good < 65535) m_good++;
            end
         end
      end
      b_byte.delete();
      b_er.delete();
      b_cyc.delete();
   endfunction

   function automatic void model_step(input bit rst, input bit dv, input bit er, input logic [7:0] d);
      if (rst) begin
         b_byte.delete();
         b_er.delete();
         b_cyc.delete();
         in_burst = dv;
         b_drop   = 1'b1;
         rst_prev = 1'b1;
         m_good   = 0;
         m_bad    = 0;
      end else begin
         if (dv) begin
            if (!in_burst) begin
               in_burst = 1'b1;
               b_drop   = rst_prev;
            end
            b_byte.push_back(d);
            b_er.push_back(er);
            b_cyc.push_back(cyc);
         end else if (in_burst) begin
            model_end_burst();
            in_burst = 1'b0;
         end
         rst_prev = 1'b0;
      end
   endfunction

   task automatic drv(input bit rst, input bit dv, input bit er, input logic [7:0] d);
      @(negedge sys_clk);
      sys_rst    = rst;
      gmii_rx_dv = dv;
      gmii_rx_er = er;
      gmii_rxd   = d;
      model_step(rst, dv, er, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic make_frame(input int plen);
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
      c = crc_of(frm);
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
      frm.push_back(c[23:16]);
      frm.push_back(c[31:24]);
   endtask

   task automatic send(input int npre, input int er_idx);
      for (int i = 0; i < npre; i++) drv(1'b0, 1'b1, 1'b0, 8'h55);
      drv(1'b0, 1'b1, 1'b0, 8'hD5);
      for (int k = 0; k < frm.size(); k++) drv(1'b0, 1'b1, k == er_idx, frm[k]);
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_good_cnt"}, 64'(good_cnt), 64'(m_good));
      chk({tag, "_bad_cnt"}, 64'(bad_cnt), 64'(m_bad));
   endtask

   // Output monitor: rebuilds frames from the stream and compares each against the model
   logic [7:0] cur[$];
   bit         in_frame = 1'b0;
   int         sop_cyc = 0;
   int         e_len, e_sop, e_eop, nbad;
   bit         e_err;
   logic [7:0] eb;

   always @(posedge sys_clk) begin
      #1;
      if (sys_rst) begin
         cur.delete();
         in_frame = 1'b0;
         chk("outputs_in_reset", 64'({rx_valid, rx_sop, rx_eop, rx_err, rx_data, good_cnt, bad_cnt}), 64'd0);
      end else begin
         if (in_frame) begin
            chk("valid_continuous", 64'(rx_valid), 64'd1);
            if (!rx_valid) in_frame = 1'b0;
         end
         if (rx_valid) begin
            if (rx_sop) begin
               chk("sop_inside_frame", 64'(in_frame), 64'd0);
               cur.delete();
               in_frame = 1'b1;
               sop_cyc  = cyc;
            end else begin
               chk("byte_after_sop", 64'(in_frame), 64'd1);
            end
            cur.push_back(rx_data);
            if (rx_eop) begin
               chk("frame_expected", 64'(exp_len.size() > 0), 64'd1);
               if (exp_len.size() > 0) begin
                  e_len = exp_len.pop_front();
                  e_err = exp_err.pop_front();
                  e_sop = exp_sop.pop_front();
                  e_eop = exp_eop.pop_front();
                  nbad  = 0;
                  for (int k = 0; k < e_len; k++) begin
                     eb = exp_byte.pop_front();
                     if (k >= cur.size() || cur[k] !== eb) nbad++;
                  end
                  chk("frame_len", 64'(cur.size()), 64'(e_len));
                  chk("frame_bytes_wrong", 64'(nbad), 64'd0);
                  chk("frame_err", 64'(rx_err), 64'(e_err));
                  chk("sop_cycle", 64'(sop_cyc), 64'(e_sop));
                  chk("eop_cycle", 64'(cyc), 64'(e_eop));
               end
               in_frame = 1'b0;
            end
         end else begin
            chk("pulse_without_valid", 64'({rx_sop, rx_eop}), 64'd0);
         end
      end
   end

   int kind, plen, npre, eidx, idx;

   initial begin
      for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 1'b0, 8'h00);
      idle(3);
      chk_cnt("after_reset");

      // Minimum good frame, then the same frame with a flipped payload bit
      make_frame(60);
      send(7, -1);
      idle(5);
      chk_cnt("good64");
      make_frame(60);
      frm[17] ^= 8'h08;
      send(7, -1);
      idle(5);
      chk_cnt("bitflip");

      // Undersize, oversize, rx_er inside data
      make_frame(56);
      send(7, -1);
      idle(2);
      make_frame(1515);
      send(7, -1);
      idle(2);
      make_frame(60);
      send(7, 10);
      idle(5);
      chk_cnt("len_and_er");

      // Junk burst followed one cycle later by a good frame
      drv(1'b0, 1'b1, 1'b0, 8'hAA);
      for (int i = 0; i < 6; i++) drv(1'b0, 1'b1, 1'b0, 8'(i));
      idle(1);
      make_frame(60);
      send(7, -1);
      idle(1);

      // One-byte frame, SFD-only burst, preamble-only burst
      frm.delete();
      frm.push_back(8'h3C);
      send(2, -1);
      idle(1);
      frm.delete();
      send(3, -1);
      idle(1);
      for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 1'b0, 8'h55);
      idle(5);
      chk_cnt("short_bursts");

      // Reset mid-frame while rx_dv stays high
      make_frame(100);
      for (int i = 0; i < 7; i++) drv(1'b0, 1'b1, 1'b0, 8'h55);
      drv(1'b0, 1'b1, 1'b0, 8'hD5);
      for (int k = 0; k < 30; k++) drv(1'b0, 1'b1, 1'b0, frm[k]);
      for (int k = 30; k < 33; k++) drv(1'b1, 1'b1, 1'b0, frm[k]);
      for (int k = 33; k < 53; k++) drv(1'b0, 1'b1, 1'b0, frm[k]);
      idle(3);
      make_frame(60);
      send(7, -1);
      idle(5);
      chk_cnt("after_mid_reset");

      // Random traffic with tight inter-frame gaps
      for (int f = 0; f < 30; f++) begin
         kind = $urandom_range(0, 9);
         plen = $urandom_range(50, 90);
         npre = $urandom_range(0, 8);
         eidx = -1;
         if (kind == 3) plen = $urandom_range(0, 6);
         make_frame(plen);
         if (kind == 0) begin
            idx = $urandom_range(0, plen + 3);
            frm[idx] ^= 8'(1 << $urandom_range(0, 7));
         end
         if (kind == 1) drv(1'b0, 1'b1, 1'b0, 8'hA0 + 8'($urandom_range(0, 15)));
         if (kind == 2) eidx = $urandom_range(0, plen + 3);
         send(npre, eidx);
         idle($urandom_range(1, 3));
      end
      idle(5);
      chk_cnt("random");

      // Counter saturation from a preloaded value
      dut.good_cnt = 16'hFFFE;
      m_good = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         make_frame(60);
         send(7, -1);
         idle(1);
      end
      idle(5);
      chk("good_cnt_saturated", 64'(good_cnt), 64'h0000_0000_0000_FFFF);
      chk_cnt("saturation");

      idle(10);
      chk("frames_outstanding", 64'(exp_len.size()), 64'd0);
      chk("frame_open_at_end", 64'(in_frame), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gmii_rx_framer.md
GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum legal frame length in bytes, counted from first byte after SFD through the FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum legal frame length in bytes, counted the same way.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge; driven from the per-port gmii rx clock domain.
REQ-004 SHALL have port sys_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port gmii_rxd  input  8  receive byte from rgmii_io.
REQ-006 SHALL have port gmii_rx_dv  input  1  receive data valid.
REQ-007 SHALL have port gmii_rx_er  input  1  receive error.
REQ-008 SHALL have port rx_data  output  8  frame byte, FCS included.
REQ-009 SHALL have port rx_valid  output  1  rx_data valid this cycle; no backpressure.
REQ-010 SHALL have port rx_sop  output  1  first byte of frame.
REQ-011 SHALL have port rx_eop  output  1  last byte of frame.
REQ-012 SHALL have port rx_err  output  1  frame bad; meaningful only with rx_eop.
REQ-013 SHALL have port good_cnt  output  16  good-frame counter, saturating.
REQ-014 SHALL have port bad_cnt  output  16  bad-frame counter, saturating.

Function
REQ-015 SHALL implement FSM IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: on rx_dv=1 with 0x55 -> PREAMBLE; with 0xD5 -> DATA; any other byte -> DROP.
REQ-017 PREAMBLE: 0x55 stays; 0xD5 (SFD) -> DATA; other byte -> DROP; rx_dv=0 -> IDLE, with no output and no count.
REQ-018 DATA: forward every rx_dv=1 byte; rx_dv=0 ends frame -> IDLE.
REQ-019 DROP: no output; exit to IDLE on the first cycle with rx_dv=0.
REQ-020 Preamble and SFD SHALL never appear on rx_data.
REQ-021 Latency SHALL be fixed at 2 cycles from gmii sample to rx_valid, using a one-byte hold stage so rx_eop marks the byte followed by rx_dv=0.
REQ-022 rx_valid SHALL be continuous for the whole frame; rx_sop and rx_eop SHALL be single-cycle pulses.
REQ-023 A 1-byte frame SHALL assert rx_sop and rx_eop in the same cycle.
REQ-024 Length counter SHALL be 11 bits and saturate at 2047.
REQ-025 rx_err at eop = rx_er seen in DATA | length < MIN_LEN | length > MAX_LEN | CRC fail (REQ-031).
REQ-026 Oversize frames SHALL be forwarded in full and flagged, not truncated.
REQ-027 At each eop, exactly one of good_cnt/bad_cnt SHALL increment; each saturates at 0xFFFF without wrapping.
REQ-028 A new rx_dv=1 in the cycle directly after frame end SHALL be processed from IDLE with no lost byte.

Reset
REQ-029 While sys_rst=1, SHALL hold FSM=IDLE and clear all outputs, counters, and the hold stage; a frame in flight is discarded with no eop.
REQ-030 If rx_dv=1 on the first cycle after reset release, SHALL enter DROP and wait for rx_dv=0.

Configuration
REQ-031 With RX_CRC_CHECK_EN defined, SHALL compute CRC-32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF) over all DATA bytes including FCS; frame fails if final register != 0xDEBB20E3.
REQ-032 Without RX_CRC_CHECK_EN, SHALL omit CRC logic entirely; the CRC term of rx_err is 0 and all other behaviour is identical.

Verification
REQ-033 7x0x55, 0xD5, then 60 payload bytes + correct FCS (64 bytes) -> 64 rx_valid cycles; sop on byte 0, eop on byte 63; rx_err=0; good_cnt=1.
REQ-034 Same frame with one payload bit flipped -> rx_err=1 and bad_cnt=1 with RX_CRC_CHECK_EN; rx_err=0 and good_cnt=1 without it.
REQ-035 Valid 60-byte frame (MIN_LEN-4) -> rx_err=1; 1519-byte frame -> all 1519 bytes forwarded, rx_err=1.
REQ-036 rx_dv burst starting with 0xAA, then a good 64-byte frame 1 cycle later -> first burst gives no output; second frame is good.
REQ-037 sys_rst pulsed mid-DATA while rx_dv stays high for 20 more cycles -> outputs 0 during reset, no eop, DROP until rx_dv=0; next frame is good.
REQ-038 Preload good_cnt=0xFFFE, send 3 good frames -> good_cnt=0xFFFF; bad_cnt unchanged.
